instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 Parameter MEM_TIMEOUT, default 16: maximum cycles to wait for imem_ack before flagging a fault.
REQ-003 clk  input  1  single system clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 imem_req  output  1  instruction-memory read request, held until acknowledged.
REQ-006 imem_addr  output  32  word-aligned fetch address; equals pc while imem_req=1.
REQ-007 imem_ack  input  1  one-cycle pulse; imem_rdata is valid in the same cycle.
REQ-008 imem_rdata  input  32  instruction word.
REQ-009 stall  input  1  back end is not ready; hold the current instruction.
REQ-010 jump  input  1  decoder jump indication for the instruction currently presented.
REQ-011 op  output  6  instr[31:26] of the held instruction, which drives the decoder op input.
REQ-012 func  output  4  instr[3:0] of the held instruction, which drives the decoder func input.
REQ-013 rs, rt, rd  output  5 each  instr[25:21], instr[20:16] and instr[15:11].
REQ-014 imm  output  16  instr[15:0].
REQ-015 pc  output  32  address of the held instruction.
REQ-016 instr_valid  output  1  op, func, rs, rt, rd and imm carry a fetched instruction.
REQ-017 fetch_fault  output  1  sticky flag set on memory timeout.

Function
REQ-018 FSM states: FETCH, HOLD and FAULT; the state after reset is FETCH.
REQ-019 In FETCH, imem_req=1 and imem_addr=pc, both stable until imem_ack.
REQ-020 In FETCH with imem_ack=1, the instruction register latches imem_rdata, the FSM moves to HOLD, and instr_valid=1 from the next cycle.
REQ-021 Fetch latency is 1 cycle after imem_ack, giving a minimum of 2 cycles per instruction with a zero-wait-state memory.
REQ-022 In HOLD with stall=1, all outputs and the PC hold their values, and jump is ignored.
REQ-023 In HOLD with stall=0 and jump=0, pc <= pc+4, instr_valid <= 0, and the FSM moves to FETCH.
REQ-024 In HOLD with stall=0 and jump=1, pc <= {pc[31:28], instr[25:0], 2'b00}, instr_valid <= 0, and the FSM moves to FETCH.
REQ-025 PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
REQ-026 pc[1:0] is always 2'b00.
REQ-027 An imem_ack received outside FETCH is ignored and leaves no state change.
REQ-028 A wait counter counts FETCH cycles without ack and clears on ack.
REQ-029 When the wait count reaches MEM_TIMEOUT, the FSM moves to FAULT.
REQ-030 In FAULT, fetch_fault=1, imem_req=0 and instr_valid=0; the FSM leaves FAULT only on reset.
REQ-031 With stall=1 and jump=1 together, stall wins; jump is re-sampled on the first cycle stall=0.
REQ-032 While instr_valid=0, op and func output 0, so the decoder sees a NOP (op=000000, func=0000).

Reset
REQ-033 Asserting rst_n=0 immediately sets pc=RESET_PC, imem_req=0, instr_valid=0, fetch_fault=0, instruction register=0, wait counter=0 and state=FETCH, independent of clk.
REQ-034 Reset during an outstanding fetch abandons the fetch; a late imem_ack after reset release does not load the instruction register unless the block is in FETCH.
REQ-035 The first imem_req=1 appears on the first rising edge after rst_n is released.

Structure
REQ-036 A shared package cpu_pkg holds the opcode/func field positions, OP_NOP, INSTR_W=32 and the fetch FSM state encoding.
REQ-037 The wait counter is one sub-module, fetch_timer, with clear, enable and expired signals.
REQ-038 The block is otherwise flat and has no combinational path from imem_rdata to op or func.

Verification
REQ-039 Scenario, reset then zero-wait memory returning 32'h0000_0020:
- Required response: imem_addr=0, then op=000000 and func=0000 with instr_valid=1.
- Next imem_addr=4.
REQ-040 Scenario, instruction 32'h0800_0010 held with jump=1 and stall=0 at pc=32'h1000_0000: next imem_addr=32'h1000_0040.
REQ-041 Scenario, stall=1 for 5 cycles in HOLD with jump toggling: pc, op and func are unchanged and no imem_req is issued.
REQ-042 Scenario, no imem_ack for 16 cycles: fetch_fault=1 and imem_req=0; the fault persists until rst_n=0.
REQ-043 Scenario, pc=32'hFFFF_FFFC advancing with jump=0: next imem_addr=32'h0000_0000.
REQ-044 Scenario, rst_n pulsed low mid-FETCH, followed by a stray imem_ack:
- Required response: pc=RESET_PC and instr_valid=0.
- The stray ack is ignored unless the block is in FETCH.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: instruction field positions, NOP encoding and fetch FSM encoding
// shared by the fetch front end.
package cpu_pkg;
    localparam int INSTR_W  = 32;
    localparam int OP_MSB   = 31;
    localparam int OP_LSB   = 26;
    localparam int FUNC_MSB = 3;
    localparam int FUNC_LSB = 0;
    localparam logic [OP_MSB-OP_LSB:0]     OP_NOP   = '0;
    localparam logic [FUNC_MSB-FUNC_LSB:0] FUNC_NOP = '0;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        FAULT = 2'd2
    } fetch_state_e;

    // Absolute jump stays inside the current 256 MB region.
    function automatic logic [INSTR_W-1:0] jump_target(input logic [INSTR_W-1:0] pc,
                                                       input logic [25:0] target);
        return {pc[31:28], target, 2'b00};
    endfunction
endpackage

// File: rtl/fetch_timer.sv
// fetch_timer: counts consecutive unacknowledged request cycles and flags
// expiry on the LIMIT-th one.
module fetch_timer #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);
    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] cnt_q, cnt_d;

    assign expired_o = enable_i && !clear_i && (cnt_q == W'(LIMIT - 1));

    always_comb cnt_d = clear_i ? '0 : enable_i ? cnt_q + W'(1) : cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: single-outstanding instruction fetch with a held instruction
// register, stall/jump handling and a sticky memory-timeout fault.
module instr_fetch import cpu_pkg::*; #(
    parameter logic [INSTR_W-1:0] RESET_PC    = 32'h0000_0000,
    parameter int                 MEM_TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [INSTR_W-1:0] imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               stall,
    input  logic               jump,
    output logic [5:0]         op,
    output logic [3:0]         func,
    output logic [4:0]         rs,
    output logic [4:0]         rt,
    output logic [4:0]         rd,
    output logic [15:0]        imm,
    output logic [INSTR_W-1:0] pc,
    output logic               instr_valid,
    output logic               fetch_fault
);
    fetch_state_e       state_q, state_d;
    logic [INSTR_W-1:0] pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               live_q;
    logic               expired;

    // live_q keeps imem_req low until the first clock edge after reset release.
    assign imem_req    = live_q && (state_q == FETCH);
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign instr_valid = (state_q == HOLD);
    assign fetch_fault = (state_q == FAULT);
    assign op          = instr_valid ? instr_q[OP_MSB:OP_LSB] : OP_NOP;
    assign func        = instr_valid ? instr_q[FUNC_MSB:FUNC_LSB] : FUNC_NOP;
    assign rs          = instr_q[25:21];
    assign rt          = instr_q[20:16];
    assign rd          = instr_q[15:11];
    assign imm         = instr_q[15:0];

    fetch_timer #(.LIMIT(MEM_TIMEOUT)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear_i  (!imem_req || imem_ack),
        .enable_i (imem_req),
        .expired_o(expired)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        unique case (state_q)
            FETCH: begin
                if (imem_req && imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = HOLD;
                end else if (expired) begin
                    state_d = FAULT;
                end
            end
            HOLD: begin
                if (!stall) begin
                    pc_d    = jump ? jump_target(pc_q, instr_q[25:0]) : pc_q + 32'd4;
                    state_d = FETCH;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
            pc_q    <= {RESET_PC[INSTR_W-1:2], 2'b00};
            instr_q <= '0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            live_q  <= 1'b1;
        end
    end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed fetch sequences; expected fetch addresses and
// decoded fields are queued by the stimulus and checked by a monitor.
module tb_instr_fetch;
    logic        clk = 1'b0, rst_n = 1'b0, imem_ack = 1'b0, stall = 1'b0, jump = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        imem_req, instr_valid, fetch_fault;
    logic [31:0] imem_addr, pc;
    logic [5:0]  op;
    logic [3:0]  func;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;

    int checks = 0, errors = 0;
    logic [31:0] addr_q[$];
    logic [41:0] dec_q[$];

    instr_fetch #(.RESET_PC(32'h0), .MEM_TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall), .jump(jump),
        .op(op), .func(func), .rs(rs), .rt(rt), .rd(rd), .imm(imm), .pc(pc),
        .instr_valid(instr_valid), .fetch_fault(fetch_fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every new fetch request and every newly valid instruction is scored.
    initial begin
        logic rq = 1'b0, vl = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (imem_req && !rq) begin
                if (addr_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL fetch_addr: unexpected request at %h, none expected", imem_addr);
                end else check("fetch_addr", imem_addr, addr_q.pop_front());
            end
            rq = imem_req;
            if (instr_valid && !vl) begin
                if (dec_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL decode: unexpected instruction op %h pc %h, none expected", op, pc);
                end else check("decode_op_func_pc", {op, func, pc}, dec_q.pop_front());
            end
            vl = instr_valid;
        end
    end

    task automatic expect_fetch(input logic [31:0] addr, input logic [5:0] eop, input logic [3:0] efn);
        addr_q.push_back(addr);
        dec_q.push_back({eop, efn, addr});
    endtask

    task automatic serve(input logic [31:0] addr, input logic [31:0] data,
                         input logic jmp, input logic stl, input int waits);
        int n = 0;
        while (!imem_req && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!imem_req) begin
            checks++; errors++;
            $display("FAIL req_timeout: imem_req=%b for addr %h, required 1", imem_req, addr);
            return;
        end
        for (int i = 0; i < waits; i++) begin
            @(negedge clk);
            check("addr_stable", {imem_req, imem_addr}, {1'b1, addr});
        end
        imem_ack = 1'b1; imem_rdata = data; jump = jmp; stall = stl;
        @(negedge clk);
        imem_ack = 1'b0; imem_rdata = '0;
    endtask

    task automatic fetch(input logic [31:0] addr, input logic [31:0] data, input logic [5:0] eop,
                         input logic [3:0] efn, input logic jmp, input logic stl, input int waits);
        expect_fetch(addr, eop, efn);
        serve(addr, data, jmp, stl, waits);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        #3;
        check("reset_state", {pc, imem_req, instr_valid, fetch_fault, op, func},
              {32'h0, 1'b0, 1'b0, 1'b0, 6'h0, 4'h0});
        @(negedge clk);
        rst_n = 1'b1;
        fetch(32'h0, 32'h0000_0020, 6'h00, 4'h0, 0, 0, 0);
        fetch(32'h4, 32'h8C22_0005, 6'h23, 4'h5, 0, 0, 2);
        fetch(32'h8, 32'h03FF_FFFF, 6'h00, 4'hF, 1, 0, 0);
        fetch(32'h0FFF_FFFC, 32'h0, 6'h00, 4'h0, 0, 0, 0);
        fetch(32'h1000_0000, 32'h0800_0010, 6'h02, 4'h0, 1, 0, 0);
        fetch(32'h1000_0040, 32'h1234_5678, 6'h04, 4'h8, 0, 1, 0);
        for (int i = 0; i < 5; i++) begin
            jump = ~jump;
            @(negedge clk);
            check("stall_hold", {pc, op, func, imem_req, instr_valid},
                  {32'h1000_0040, 6'h04, 4'h8, 1'b0, 1'b1});
        end
        check("fields", {rs, rt, rd, imm}, {5'h11, 5'h14, 5'h0A, 16'h5678});
        stall = 1'b0; jump = 1'b1;
        fetch(32'h18D1_59E0, 32'h0, 6'h00, 4'h0, 0, 0, 3);
        fetch(32'h18D1_59E4, 32'h03FF_FFFF, 6'h00, 4'hF, 1, 0, 0);
        fetch(32'h1FFF_FFFC, 32'h0, 6'h00, 4'h0, 0, 0, 0);
        for (int k = 2; k < 16; k++) begin
            fetch({k[3:0], 28'h0}, 32'h03FF_FFFF, 6'h00, 4'hF, 1, 0, 0);
            fetch({k[3:0], 28'hFFF_FFFC}, 32'h0, 6'h00, 4'h0, 0, 0, 0);
        end
        fetch(32'h0, 32'h0400_0001, 6'h01, 4'h1, 0, 0, 0);
        addr_q.push_back(32'h4);
        n = 0;
        while (!imem_req && n < 40) begin
            @(negedge clk);
            n++;
        end
        repeat (15) @(negedge clk);
        check("timeout_boundary", {fetch_fault, imem_req}, {1'b0, 1'b1});
        @(negedge clk);
        check("timeout_fault", {fetch_fault, imem_req, instr_valid}, {1'b1, 1'b0, 1'b0});
        imem_ack = 1'b1; imem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        imem_ack = 1'b0;
        repeat (3) @(negedge clk);
        check("fault_sticky", {fetch_fault, imem_req, instr_valid, op, func, pc},
              {1'b1, 1'b0, 1'b0, 6'h0, 4'h0, 32'h4});
        #2 rst_n = 1'b0;
        #1 check("async_reset", {pc, imem_req, instr_valid, fetch_fault},
                 {32'h0, 1'b0, 1'b0, 1'b0});
        @(negedge clk);
        addr_q.push_back(32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("req_after_release", {imem_req, imem_addr}, {1'b1, 32'h0});
        #2 rst_n = 1'b0;
        #1 check("reset_mid_fetch", {pc, imem_req, instr_valid}, {32'h0, 1'b0, 1'b0});
        imem_ack = 1'b1; imem_rdata = 32'hFFFF_FFFF;
        repeat (2) @(negedge clk);
        expect_fetch(32'h0, 6'h01, 4'h1);
        rst_n = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0; imem_rdata = '0;
        check("stray_ack_ignored", {instr_valid, op, func, imem_req, pc},
              {1'b0, 6'h0, 4'h0, 1'b1, 32'h0});
        serve(32'h0, 32'h0400_0001, 0, 1, 0);
        repeat (3) @(negedge clk);
        check("queues_drained", {32'(addr_q.size()), 32'(dec_q.size())}, 64'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
